// File: rtl/uart_pkg.sv
// UART receiver shared types and default constants.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 16;
  localparam int DATA_BITS_DEF    = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side result bundle of uart_rx.
// The master drives data, strobes and busy; the slave consumes them.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF
);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 busy;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output parity_err,
    output busy
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input frame_err,
    input parity_err,
    input busy
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop single-bit synchronizer.
// Both flops reset to RST_VAL.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling, break detection.
// Define UART_RX_PARITY_EN to add one even-parity bit per frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_cpb
    $error("uart_rx: CLKS_PER_BIT must be 4 or more");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_db
    $error("uart_rx: DATA_BITS must be 5..8");
  end

  logic                 rx_s;
  uart_state_e          state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic perr_q;
  logic par_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_q  <= 1'b0;
      par_bad <= 1'b0;
    end else begin
      perr_q <= 1'b0;
      if (state == ST_PARITY && cnt == BIT_END) begin
        par_bad <= rx_s ^ (^shift);
      end
      // Stop-bit low takes precedence so only one strobe fires
      if (state == ST_STOP && cnt == BIT_END) begin
        perr_q <= rx_s & par_bad;
      end
    end
  end

  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state   <= ST_START;
            cnt     <= '0;
            bit_cnt <= '0;
          end
        end
        ST_START: begin
          if (cnt == HALF_END) begin
            cnt   <= '0;
            state <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == BIT_END) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt == BIT_END) begin
            cnt   <= '0;
            state <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (cnt == BIT_END) begin
            cnt <= '0;
            if (!rx_s) begin
              ferr_q <= 1'b1;
              state  <= ST_BREAK;
            end else begin
              state <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
              if (!par_bad) begin
                valid_q <= 1'b1;
                data_q  <= shift;
              end
`else
              valid_q <= 1'b1;
              data_q  <= shift;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_BREAK: begin
          if (rx_s) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a frame-level expectation model.
// Build with UART_RX_PARITY_EN to also exercise the parity bit.
module tb_uart_rx;

  localparam int C  = 16;
  localparam int DB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam logic [2:0] K_VALID = 3'b100;
  localparam logic [2:0] K_FERR  = 3'b010;
  localparam logic [2:0] K_PERR  = 3'b001;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
    int         due;
  } exp_t;

  logic clk;
  logic rst_n;
  logic rx;

  uart_rx_if #(.DATA_BITS(DB)) bus ();

  uart_rx #(
    .CLKS_PER_BIT(C),
    .DATA_BITS   (DB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rx   (rx),
    .bus  (bus)
  );

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_valid = 0;
  int   n_ferr = 0;
  int   n_perr = 0;
  int   last_valid_cyc = -1;
  int   t0_last = 0;
  logic [7:0] model_data = '0;
  exp_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic chk_rng(input string nm, input int act,
                         input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)",
               nm, act, lo, hi, cyc);
    end
  endtask

  // Drives one frame starting at a negedge; records what the line must yield.
  task automatic send_frame(input logic [7:0] d, input logic par_bit,
                            input logic stop_bit);
    exp_t e;
    rx      = 1'b0;
    t0_last = cyc;
    e.data  = d;
    e.due   = t0_last + (DB + 1 + PB) * C + C / 2 + 3;
    if (!stop_bit)
      e.kind = K_FERR;
    else if (PB == 1 && par_bit != ^d)
      e.kind = K_PERR;
    else
      e.kind = K_VALID;
    exp_q.push_back(e);
    repeat (C) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      repeat (C) @(negedge clk);
    end
    if (PB == 1) begin
      rx = par_bit;
      repeat (C) @(negedge clk);
    end
    rx = stop_bit;
    repeat (C) @(negedge clk);
  endtask

  initial begin : cmp
    logic [2:0] s;
    logic [2:0] prev;
    exp_t       e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        model_data = '0;
        prev = '0;
        continue;
      end
      s = {bus.rx_valid, bus.frame_err, bus.parity_err};
      if (s != 3'b000) begin
        chk("strobe_onehot", $countones(s), 1);
        chk("strobe_gap", prev, 0);
        if (s[2]) begin
          n_valid++;
          last_valid_cyc = cyc;
        end
        if (s[1]) n_ferr++;
        if (s[0]) n_perr++;
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", s, 0);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_kind", s, e.kind);
          chk_rng("strobe_time", cyc, e.due - 1, e.due + 1);
          if (e.kind == K_VALID) begin
            chk("rx_data_load", bus.rx_data, e.data);
            model_data = e.data;
          end
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].due + 1) begin
        chk("missed_strobe", 0, exp_q[0].kind);
        void'(exp_q.pop_front());
      end
      if (!s[2]) chk("rx_data_hold", bus.rx_data, model_data);
      prev = s;
    end
  end

  initial begin : main
    int cnt;
    int v0;
    int f0;
    int p0;
    rx    = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_rx_data", bus.rx_data, 0);
    chk("rst_strobes",
        {bus.rx_valid, bus.frame_err, bus.parity_err}, 0);
    chk("rst_busy", bus.busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.busy) cnt++;
    end
    chk("idle_after_reset_busy_cycles", cnt, 0);

    // 0xA5, 8N1: latency and data
    last_valid_cyc = -1;
    v0 = n_valid;
    send_frame(8'hA5, ^8'hA5, 1'b1);
    chk_rng("a5_latency", last_valid_cyc - t0_last, 154, 156);
    chk("a5_data", bus.rx_data, 8'hA5);
    chk("a5_valid_count", n_valid - v0, 1);
    chk("a5_err_count", n_ferr + n_perr, 0);
    repeat (2 * C) @(negedge clk);

    // 5-cycle glitch is a false start
    v0 = n_valid; f0 = n_ferr; p0 = n_perr;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.busy) cnt++;
    end
    chk_rng("glitch_busy_cycles", cnt, 1, 10);
    chk("glitch_busy_end", bus.busy, 0);
    chk("glitch_strobes", (n_valid - v0) + (n_ferr - f0) + (n_perr - p0), 0);

    // 0x3C with stop low, then a 40-bit break
    f0 = n_ferr;
    send_frame(8'h3C, ^8'h3C, 1'b0);
    repeat (40 * C) @(negedge clk);
    chk("break_ferr_count", n_ferr - f0, 1);
    chk("break_busy_held", bus.busy, 1);
    chk("break_data_kept", bus.rx_data, 8'hA5);
    rx = 1'b1;
    cnt = 0;
    while (bus.busy && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk_rng("break_release_cycles", cnt, 2, 4);
    repeat (2 * C) @(negedge clk);

    // Back-to-back frames with no idle gap
    v0 = n_valid;
    send_frame(8'h00, ^8'h00, 1'b1);
    send_frame(8'hFF, ^8'hFF, 1'b1);
    send_frame(8'h81, ^8'h81, 1'b1);
    chk("b2b_valid_count", n_valid - v0, 3);
    chk("b2b_last_data", bus.rx_data, 8'h81);
    repeat (2 * C) @(negedge clk);

    // Reset during data bit 4 of 0x55 aborts the frame
    v0 = n_valid; f0 = n_ferr; p0 = n_perr;
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = (8'h55 >> i) & 8'h01;
      repeat (C) @(negedge clk);
    end
    rx = 1'b1;
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midframe_rst_busy", bus.busy, 0);
    chk("midframe_rst_data", bus.rx_data, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2 * C) @(negedge clk);
    chk("aborted_strobes", (n_valid - v0) + (n_ferr - f0) + (n_perr - p0), 0);
    send_frame(8'h12, ^8'h12, 1'b1);
    chk("after_reset_valid", n_valid - v0, 1);
    chk("after_reset_data", bus.rx_data, 8'h12);
    repeat (2 * C) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit must be 1
    v0 = n_valid; p0 = n_perr;
    send_frame(8'h07, 1'b0, 1'b1);
    chk("par_bad_perr", n_perr - p0, 1);
    chk("par_bad_no_valid", n_valid - v0, 0);
    chk("par_bad_data_kept", bus.rx_data, 8'h12);
    repeat (2 * C) @(negedge clk);
    send_frame(8'h07, 1'b1, 1'b1);
    chk("par_ok_valid", n_valid - v0, 1);
    chk("par_ok_data", bus.rx_data, 8'h07);
    repeat (2 * C) @(negedge clk);
`endif

    repeat (10) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per UART bit; legal values are 4 or more.
REQ-002 The block SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal range is 5 to 8.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port rx, input, 1 bit: raw serial line, asynchronous to clk, idle high.
REQ-006 The block SHALL have port rx_data, output, DATA_BITS wide: last received byte, LSB = first data bit.
REQ-007 The block SHALL have port rx_valid, output, 1 bit: single-cycle strobe marking a good frame.
REQ-008 The block SHALL have port frame_err, output, 1 bit: single-cycle strobe when the stop bit is sampled low.
REQ-009 The block SHALL have port parity_err, output, 1 bit: single-cycle strobe on parity mismatch.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value rx_s.
REQ-012 The FSM states SHALL be IDLE, START, DATA, PARITY (when compiled in), STOP and BREAK.
REQ-013 IDLE -> START SHALL occur on the first cycle rx_s is low; the bit counter clears.
REQ-014 START: after CLKS_PER_BIT/2 cycles (integer division), rx_s SHALL be resampled; low -> DATA, high -> IDLE as a false start with no strobe.
REQ-015 DATA: every CLKS_PER_BIT cycles, rx_s SHALL be shifted in LSB-first; after DATA_BITS samples -> PARITY if enabled, else STOP.
REQ-016 STOP: after CLKS_PER_BIT cycles, rx_s SHALL be sampled; high with no parity error -> rx_valid=1 for exactly one cycle, rx_data loaded in that same cycle, -> IDLE.
REQ-017 A stop sample of 0 SHALL pulse frame_err for one cycle, leave rx_data unchanged, suppress rx_valid and go to BREAK.
REQ-018 BREAK SHALL stay until rx_s is high, then go to IDLE; a held-low line (break) SHALL produce exactly one frame_err.
REQ-019 rx_valid, frame_err and parity_err SHALL be mutually exclusive and never high on two consecutive cycles.
REQ-020 rx_data SHALL hold its value between rx_valid strobes.
REQ-021 rx_valid SHALL rise 9.5*CLKS_PER_BIT+3 cycles (+/-1) after a raw rx falling edge, for DATA_BITS=8 without parity.
REQ-022 Back-to-back frames, with the next start edge immediately after the stop-bit mid-sample, SHALL be received without loss.
REQ-023 Bit and sample counters SHALL be sized $clog2(CLKS_PER_BIT) and $clog2(DATA_BITS+1) bits and SHALL never wrap mid-bit.

Reset
REQ-024 On rst_n low, the block SHALL immediately go to IDLE, with synchronizer flops = 1, rx_data = 0 and all strobes and busy = 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no strobe; reception SHALL resume on the first falling edge after rst_n deasserts.

Configuration
REQ-026 With UART_RX_PARITY_EN defined, one even-parity bit SHALL follow the data bits (PARITY state, one bit period); a mismatch SHALL pulse parity_err, suppress rx_valid and still check the stop bit.
REQ-027 Without UART_RX_PARITY_EN, the PARITY state and its logic SHALL be absent and parity_err SHALL be tied 0.

Structure
REQ-028 The package uart_pkg SHALL hold the FSM state enum typedef and the default constants CLKS_PER_BIT_DEF=16 and DATA_BITS_DEF=8.
REQ-029 The synchronizer SHALL be the sub-module sync_2ff (1-bit, async active-low reset, configurable reset value).

Verification
REQ-030 Scenario: send 0xA5 at CLKS_PER_BIT=16, 8N1 -> one rx_valid pulse, rx_data=0xA5, latency 155 +/-1 cycles, no error strobes.
REQ-031 Scenario: 5-cycle low glitch on idle rx -> no strobes; busy high for at most 10 cycles, then IDLE.
REQ-032 Scenario: 0x3C with stop bit forced 0, then line held low 40 bit times -> exactly one frame_err, rx_data unchanged, busy until the line goes high.
REQ-033 Scenario: 0x00, 0xFF, 0x81 back-to-back with no idle gap -> three rx_valid pulses, correct data, each pulse 1 cycle.
REQ-034 Scenario: rst_n low during data bit 4 of 0x55, then send 0x12 -> no strobe for 0x55, rx_valid with 0x12.
REQ-035 Scenario (UART_RX_PARITY_EN): 0x07 with parity bit 0 -> parity_err pulse, no rx_valid; with parity bit 1 -> rx_valid, rx_data=0x07.
